// File: rtl/serial_word_receiver_if.sv
// Bundle of serial input, word output handshake and error flags for serial_word_receiver.
// master = serializer/consumer side, slave = the receiver itself.
interface serial_word_receiver_if #(
  parameter int N = 4
);
  logic         s_valid;
  logic         s_data;
  logic         s_start;
  logic         dir;
  logic         out_ready;
  logic         err_clr;
  logic [N-1:0] out_word;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;
  logic         par_err;

  modport master (
    output s_valid, s_data, s_start, dir, out_ready, err_clr,
    input  out_word, out_valid, busy, overrun, frame_err, par_err
  );

  modport slave (
    input  s_valid, s_data, s_start, dir, out_ready, err_clr,
    output out_word, out_valid, busy, overrun, frame_err, par_err
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Assembles strobed serial bits into N-bit words (LSB- or MSB-first per frame) behind a one-deep output buffer.
// Define SERIAL_RX_PARITY_EN to expect a trailing even-parity bit after every frame.
module serial_word_receiver #(
  parameter int N = 4
) (
  input logic                   CLK,
  input logic                   Clear,
  serial_word_receiver_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;

  state_t       state_q;
  logic [N-1:0] sreg_q;
  logic [CW-1:0] cnt_q;
  logic         dir_q;
  logic [N-1:0] outWord_q;
  logic         outValid_q;
  logic         overrun_q;
  logic         frameErr_q;

  logic         strobe_d;
  logic         complete_d;
  logic [N-1:0] shifted_d;
  logic [N-1:0] word_d;

`ifdef SERIAL_RX_PARITY_EN
  logic         parErr_q;
  logic         parBad_d;
`endif

  // Decide whether this strobe finishes a frame and which word it delivers.
  always_comb begin
    strobe_d   = bus.s_valid && !bus.s_start;
    shifted_d  = dir_q ? {sreg_q[N-2:0], bus.s_data} : {bus.s_data, sreg_q[N-1:1]};
    word_d     = shifted_d;
    complete_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    parBad_d   = 1'b0;
    if (strobe_d && state_q == PAR) begin
      complete_d = 1'b1;
      word_d     = sreg_q;
      parBad_d   = ^{sreg_q, bus.s_data};
    end
`else
    if (strobe_d && state_q == RECV && cnt_q == CW'(N - 1)) begin
      complete_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      outWord_q  <= '0;
      outValid_q <= 1'b0;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parErr_q   <= 1'b0;
`endif
    end else begin
      // Clear first so a coincident set condition below takes priority.
      if (bus.err_clr) begin
        overrun_q  <= 1'b0;
        frameErr_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parErr_q   <= 1'b0;
`endif
      end

      if (bus.s_valid && bus.s_start) begin
        if (state_q != IDLE) frameErr_q <= 1'b1;
        dir_q   <= bus.dir;
        sreg_q  <= bus.dir ? {{(N-1){1'b0}}, bus.s_data} : {bus.s_data, {(N-1){1'b0}}};
        cnt_q   <= CW'(1);
        state_q <= RECV;
      end else if (strobe_d) begin
        case (state_q)
          RECV: begin
            sreg_q <= shifted_d;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
              state_q <= PAR;
`else
              state_q <= IDLE;
`endif
            end
          end
          PAR: begin
            state_q <= IDLE;
`ifdef SERIAL_RX_PARITY_EN
            if (parBad_d) parErr_q <= 1'b1;
`endif
          end
          default: ;
        endcase
      end

      // The buffer is free if empty or being drained this very cycle.
      if (complete_d) begin
        if (!outValid_q || bus.out_ready) begin
          outWord_q  <= word_d;
          outValid_q <= 1'b1;
        end else begin
          overrun_q  <= 1'b1;
        end
      end else if (outValid_q && bus.out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign bus.out_word  = outWord_q;
  assign bus.out_valid = outValid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frameErr_q;
`ifdef SERIAL_RX_PARITY_EN
  assign bus.par_err   = parErr_q;
`else
  assign bus.par_err   = 1'b0;
`endif
endmodule
